// File: rtl/load_store_unit.sv
// Data-memory load/store unit: byte-lane steering, extension, strobes, req/ready/rvalid handshake with timeout.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing misaligned accesses into two aligned beats.
module load_store_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   rdata,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned SB    = XLEN / 8;
  localparam int unsigned SB2   = 2 * SB;
  localparam int unsigned OFF_W = $clog2(SB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              beat_q, beat_d, two_q, two_d, store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, lo_q, lo_d, rdata_q, rdata_d;
  logic              errm_q, errm_d, errt_q, errt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  int unsigned       nb_in, nb_q;
  logic              err_in, two_in;
  logic [XLEN-1:0]   wdata_in, raw, keep, ld_ext;
  logic [2*XLEN-1:0] wwide, rd_cat;
  logic [SB2-1:0]    swide;
  logic [OFF_W+2:0]  shamt;
  logic              sign, rd_take;

  // Request decode from the live inputs (only consumed on the start edge).
  always_comb begin
    nb_in    = 32'd1 << funct3[1:0];
    wdata_in = wdata & ~({XLEN{1'b1}} << (nb_in * 8));
`ifdef LSU_MISALIGN_SPLIT_EN
    err_in = (nb_in > SB) || (is_store && funct3[2]);
    two_in = (32'(addr[OFF_W-1:0]) + nb_in) > SB;
`else
    err_in = (nb_in > SB) || (is_store && funct3[2]) ||
             ((32'(addr[OFF_W-1:0]) & (nb_in - 32'd1)) != 32'd0);
    two_in = 1'b0;
`endif
  end

  // Both beats are views of one double-width lane-shifted word; beat 1 takes the upper half.
  always_comb begin
    nb_q   = 32'd1 << f3_q[1:0];
    shamt  = {off_q, 3'b000};
    wwide  = {{XLEN{1'b0}}, wdata_q} << shamt;
    swide  = ((SB2'(1) << nb_q) - SB2'(1)) << off_q;
    rd_cat = beat_q ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
    raw    = XLEN'(rd_cat >> shamt);
    keep   = ~({XLEN{1'b1}} << (nb_q * 8));
    case (f3_q[1:0])
      2'b00:   sign = raw[7];
      2'b01:   sign = raw[15];
      2'b10:   sign = raw[31];
      default: sign = raw[XLEN-1];
    endcase
    ld_ext = (raw & keep) | (~keep & {XLEN{sign & ~f3_q[2]}});
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    two_d   = two_q;
    store_d = store_q;
    f3_d    = f3_q;
    off_d   = off_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    errm_d  = errm_q;
    errt_d  = errt_q;
    cnt_d   = cnt_q;
    rd_take = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        store_d = is_store;
        f3_d    = funct3;
        off_d   = addr[OFF_W-1:0];
        base_d  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wdata_d = wdata_in;
        beat_d  = 1'b0;
        two_d   = two_in;
        cnt_d   = '0;
        if (err_in) begin
          errm_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          cnt_d = '0;
          if (store_q) begin
            if (two_q && !beat_q) beat_d = 1'b1;
            else                  state_d = S_DONE;
          end else if (mem_rvalid) begin
            rd_take = 1'b1;
          end else begin
            state_d = S_RESP;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          errt_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          rd_take = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          errt_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        errm_d  = 1'b0;
        errt_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    if (rd_take) begin
      cnt_d = '0;
      if (two_q && !beat_q) begin
        lo_d    = mem_rdata;
        beat_d  = 1'b1;
        state_d = S_REQ;
      end else begin
        rdata_d = ld_ext;
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= 1'b0;
      two_q   <= 1'b0;
      store_q <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      errm_q  <= 1'b0;
      errt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      two_q   <= two_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      errm_q  <= errm_d;
      errt_q  <= errt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign rdata        = rdata_q;
  assign err_misalign = errm_q;
  assign err_timeout  = errt_q;
  assign mem_req      = (state_q == S_REQ);
  assign mem_we       = mem_req & store_q;
  assign mem_addr     = mem_req ? base_q + (beat_q ? ADDR_W'(SB) : '0) : '0;
  assign mem_wdata    = mem_we ? (beat_q ? wwide[2*XLEN-1:XLEN] : wwide[XLEN-1:0]) : '0;
  assign mem_wstrb    = mem_we ? (beat_q ? swide[SB2-1:SB] : swide[SB-1:0]) : '0;

endmodule
